dpc_corrector_v2: RTL and testbench

DPC_CORRECTOR_V2 -- requirements
Module: dpc_corrector_v2

---
 rtl/dpc_corrector_v2.sv | 155 +++++++++++++++
 tb/tb_dpc_corrector_v2.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpc_corrector_v2.sv
// Defective-pixel corrector: 3-stage AXI-Stream pipeline replacing flagged pixels by a neighbour mean or copy.
// Optional per-frame corrected-pixel statistics are built when DPC_STATS_EN is defined.
`timescale 1ns/1ps
module dpc_corrector_v2 #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAT_WIDTH = 20
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [WIDTH-1:0]       s_axis_tdata,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tbad,
  input  logic [8*WIDTH-1:0]     s_nb_data,
  input  logic [7:0]             s_nb_vld,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [WIDTH-1:0]       m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  input  logic                   enable,
  input  logic [1:0]             mode,
  output logic                   dbg_corrected,
  output logic [STAT_WIDTH-1:0]  stat_bp_count,
  output logic                   stat_valid
);

  localparam int unsigned SUM_W = WIDTH + 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NB    = 8;
  // w12, w21, w23, w32 in the packed neighbour order
  localparam logic [7:0] NB4_MASK = 8'h5A;

  // Reset asserts asynchronously, releases on the second aclk edge
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic adv;
  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv;

  // S1 combinational: neighbour selection, sum, count and replace decision
  logic [NB-1:0]    sel_c;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt_c;
  logic [WIDTH-1:0] copy_c;
  logic             is_copy_c;
  logic             rep_c;

  always_comb begin
    sel_c = s_nb_vld;
    if (mode == 2'd1 && (s_nb_vld & NB4_MASK) != 8'h00) sel_c = s_nb_vld & NB4_MASK;
    sum_c = '0;
    cnt_c = '0;
    for (int i = 0; i < NB; i++) begin
      if (sel_c[i]) begin
        sum_c = sum_c + SUM_W'(s_nb_data[i*WIDTH +: WIDTH]);
        cnt_c = cnt_c + CNT_W'(1);
      end
    end
    copy_c    = s_nb_vld[3] ? s_nb_data[3*WIDTH +: WIDTH] : s_nb_data[4*WIDTH +: WIDTH];
    is_copy_c = (mode == 2'd2);
    rep_c     = s_axis_tbad && enable && (mode != 2'd3) &&
                (is_copy_c ? (s_nb_vld[3] || s_nb_vld[4]) : (cnt_c != '0));
  end

  logic             v1, v2;
  logic [WIDTH-1:0] d1, d2, copy1, copy2, quot2;
  logic [SUM_W-1:0] sum1;
  logic [CNT_W-1:0] cnt1, div_c;
  logic             is_copy1, is_copy2, rep1, rep2;
  logic             user1, user2, last1, last2;

  assign div_c = (cnt1 == '0) ? CNT_W'(1) : cnt1;

  // Stage registers; everything holds while the output is stalled
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; d1 <= '0; sum1 <= '0; cnt1 <= '0; copy1 <= '0;
      is_copy1 <= 1'b0; rep1 <= 1'b0; user1 <= 1'b0; last1 <= 1'b0;
      v2 <= 1'b0; d2 <= '0; quot2 <= '0; copy2 <= '0;
      is_copy2 <= 1'b0; rep2 <= 1'b0; user2 <= 1'b0; last2 <= 1'b0;
      m_axis_tvalid <= 1'b0; m_axis_tdata <= '0; m_axis_tuser <= 1'b0;
      m_axis_tlast  <= 1'b0; dbg_corrected <= 1'b0;
    end else if (adv) begin
      v1       <= s_axis_tvalid;
      d1       <= s_axis_tdata;
      sum1     <= sum_c;
      cnt1     <= cnt_c;
      copy1    <= copy_c;
      is_copy1 <= is_copy_c;
      rep1     <= rep_c;
      user1    <= s_axis_tuser;
      last1    <= s_axis_tlast;

      v2       <= v1;
      d2       <= d1;
      quot2    <= WIDTH'(sum1 / SUM_W'(div_c));
      copy2    <= copy1;
      is_copy2 <= is_copy1;
      rep2     <= rep1;
      user2    <= user1;
      last2    <= last1;

      m_axis_tvalid <= v2;
      m_axis_tdata  <= rep2 ? (is_copy2 ? copy2 : quot2) : d2;
      m_axis_tuser  <= user2;
      m_axis_tlast  <= last2;
      dbg_corrected <= v2 && rep2;
    end
  end

`ifdef DPC_STATS_EN
  // Per-frame corrected-beat counter, published at each SOF except the first after reset
  logic [STAT_WIDTH-1:0] acc_q, stat_cnt_q;
  logic                  stat_v_q, sof_seen_q, out_fire;

  assign out_fire = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; stat_cnt_q <= '0; stat_v_q <= 1'b0; sof_seen_q <= 1'b0;
    end else begin
      stat_v_q <= 1'b0;
      if (out_fire) begin
        if (m_axis_tuser) begin
          if (sof_seen_q) begin
            stat_cnt_q <= acc_q;
            stat_v_q   <= 1'b1;
          end
          sof_seen_q <= 1'b1;
          acc_q      <= STAT_WIDTH'(dbg_corrected);
        end else if (dbg_corrected && acc_q != '1) begin
          acc_q <= acc_q + STAT_WIDTH'(1);
        end
      end
    end
  end

  assign stat_bp_count = stat_cnt_q;
  assign stat_valid    = stat_v_q;
`else
  assign stat_bp_count = '0;
  assign stat_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_dpc_corrector_v2.sv
// Bench for dpc_corrector_v2: directed vector table, stall/stat/reset sequences and a randomized run
// checked against a behavioural model of the correction rules.
`timescale 1ns/1ps
module tb_dpc_corrector_v2;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 20;
`ifdef DPC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            aclk, aresetn;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast, s_axis_tbad;
  logic [W-1:0]    s_axis_tdata;
  logic [8*W-1:0]  s_nb_data;
  logic [7:0]      s_nb_vld;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic [W-1:0]    m_axis_tdata;
  logic            enable, dbg_corrected, stat_valid;
  logic [1:0]      mode;
  logic [SW-1:0]   stat_bp_count;

  dpc_corrector_v2 #(.WIDTH(W), .STAT_WIDTH(SW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tbad(s_axis_tbad), .s_nb_data(s_nb_data), .s_nb_vld(s_nb_vld),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .enable(enable), .mode(mode), .dbg_corrected(dbg_corrected),
    .stat_bp_count(stat_bp_count), .stat_valid(stat_valid)
  );

  typedef struct {
    logic [W-1:0]   data;
    logic [8*W-1:0] nb;
    logic [7:0]     vld;
    logic           bad, en, user, last;
    logic [1:0]     mode;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    logic         user, last, rep;
  } exp_t;

  typedef struct {
    beat_t        b;
    logic [W-1:0] exp_data;
    logic         exp_rep;
  } vec_t;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, rdy_mode = 0, pulses = 0;
  exp_t exp_q[$];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    if (rdy_mode == 0)      m_axis_tready = 1'b1;
    else if (rdy_mode == 1) m_axis_tready = ($urandom_range(3) != 0);
    else                    m_axis_tready = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] nbv(input beat_t b, input int i);
    return b.nb[i*W +: W];
  endfunction

  // Correction rules stated directly: pick the neighbour list, then integer mean or copy
  function automatic exp_t model(input beat_t b);
    exp_t e;
    int   sum, cnt;
    int   four[4];
    four = '{1, 3, 4, 6};
    e.data = b.data; e.user = b.user; e.last = b.last; e.rep = 1'b0;
    if (!b.bad || !b.en || b.mode == 2'd3) return e;
    if (b.mode == 2'd2) begin
      if (b.vld[3])      begin e.data = nbv(b, 3); e.rep = 1'b1; end
      else if (b.vld[4]) begin e.data = nbv(b, 4); e.rep = 1'b1; end
      return e;
    end
    sum = 0; cnt = 0;
    if (b.mode == 2'd1)
      foreach (four[k]) if (b.vld[four[k]]) begin sum += int'(nbv(b, four[k])); cnt++; end
    if (cnt == 0)
      for (int i = 0; i < 8; i++) if (b.vld[i]) begin sum += int'(nbv(b, i)); cnt++; end
    if (cnt > 0) begin e.data = W'(sum / cnt); e.rep = 1'b1; end
    return e;
  endfunction

  function automatic logic [8*W-1:0] lin(input int base, input int step);
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*W +: W] = W'(base + step * i);
    return r;
  endfunction

  function automatic beat_t mk(input logic [W-1:0] d, input logic [8*W-1:0] nb, input logic [7:0] vld,
                               input logic bad, input logic en, input logic [1:0] md);
    beat_t b;
    b.data = d; b.nb = nb; b.vld = vld; b.bad = bad; b.en = en; b.mode = md;
    b.user = 1'b0; b.last = 1'b0;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = W'($urandom);
    for (int i = 0; i < 8; i++) b.nb[i*W +: W] = W'($urandom);
    if ($urandom_range(7) == 0) b.nb = '1;
    b.vld  = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
    b.bad  = ($urandom_range(2) != 0);
    b.en   = ($urandom_range(5) != 0);
    b.mode = 2'($urandom_range(3));
    b.user = 1'b0; b.last = 1'b0;
    return b;
  endfunction

  // Output monitor: scoreboard, stall stability and statistics expectations
  logic       hold_prev = 1'b0;
  logic [31:0] prev_out = '0;
  logic       seen = 1'b0, pend = 1'b0;
  int         acc = 0, pend_cnt = 0, held = 0;

  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      check("rst_tvalid", 32'(m_axis_tvalid), 0);
      check("rst_tdata", 32'(m_axis_tdata), 0);
      check("rst_tuser_tlast_dbg", {29'd0, m_axis_tuser, m_axis_tlast, dbg_corrected}, 0);
      check("rst_stats", {11'd0, stat_valid, stat_bp_count}, 0);
      check("rst_s_tready", 32'(s_axis_tready), 1);
      seen = 1'b0; acc = 0; pend = 1'b0; held = 0; hold_prev = 1'b0;
    end else begin
      if (pend) held = pend_cnt;
      check("stat_valid", 32'(stat_valid), STATS ? 32'(pend) : 0);
      check("stat_bp_count", 32'(stat_bp_count), STATS ? 32'(held) : 0);
      if (stat_valid) pulses++;
      pend = 1'b0;
      if (hold_prev)
        check("stall_stable", {12'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, dbg_corrected, m_axis_tdata}, prev_out);
      if (m_axis_tvalid && !m_axis_tready) check("s_tready_when_stalled", 32'(s_axis_tready), 0);
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_out  = {12'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, dbg_corrected, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got data 0x%0h, expected no beat (cycle %0d)", m_axis_tdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_axis_tdata), 32'(e.data));
          check("out_user_last", {30'd0, m_axis_tuser, m_axis_tlast}, {30'd0, e.user, e.last});
          check("dbg_corrected", 32'(dbg_corrected), 32'(e.rep));
          if (e.user) begin
            if (seen) begin pend = 1'b1; pend_cnt = acc; end
            seen = 1'b1;
            acc  = int'(e.rep);
          end else if (e.rep) begin
            acc++;
          end
        end
      end
    end
  end

  task automatic send(input beat_t b, input exp_t e);
    bit ok = 1'b0;
    s_axis_tdata = b.data; s_nb_data = b.nb; s_nb_vld = b.vld; s_axis_tbad = b.bad;
    enable = b.en; mode = b.mode; s_axis_tuser = b.user; s_axis_tlast = b.last;
    s_axis_tvalid = 1'b1;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge aclk);
      if (s_axis_tready) begin ok = 1'b1; exp_q.push_back(e); acc_cyc = cyc; end
      @(posedge aclk); #1;
    end
    if (!ok) check("input_accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 300 && exp_q.size() != 0; g++) @(negedge aclk);
    check("drain_all_beats", 32'(exp_q.size()), 0);
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] badmask, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b = mk(W'($urandom), lin(100, 100), 8'hFF, badmask[i], 1'b1, 2'd0);
      b.user = (i == 0);
      b.last = (i % 4 == 3);
      send(b, model(b));
    end
  endtask

  vec_t tbl[12];

  initial begin
    beat_t          b;
    exp_t           e;
    logic [8*W-1:0] nb;
    int             p0;
    bit             got;

    aresetn = 1'b0; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tbad = 1'b0; s_nb_data = '0; s_nb_vld = '0; enable = 1'b0; mode = 2'd0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    #1;

    tbl[0]  = '{mk(16'h0055, lin(100, 100), 8'hFF, 1, 1, 2'd0), 16'd450, 1'b1};
    nb = lin(10, 0); nb[7*W +: W] = 16'd21;
    tbl[1]  = '{mk(16'h0077, nb, 8'h81, 1, 1, 2'd1), 16'd15, 1'b1};
    tbl[2]  = '{mk(16'hABCD, lin(100, 100), 8'h00, 1, 1, 2'd0), 16'hABCD, 1'b0};
    tbl[3]  = '{mk(16'hABCD, lin(100, 100), 8'h00, 1, 1, 2'd2), 16'hABCD, 1'b0};
    tbl[4]  = '{mk(16'h0011, lin(100, 100), 8'h1A, 1, 1, 2'd1), 16'd366, 1'b1};
    tbl[5]  = '{mk(16'h0022, lin(100, 100), 8'hFF, 1, 1, 2'd2), 16'd400, 1'b1};
    tbl[6]  = '{mk(16'h0033, lin(100, 100), 8'hF7, 1, 1, 2'd2), 16'd500, 1'b1};
    tbl[7]  = '{mk(16'h1234, lin(100, 100), 8'hFF, 1, 1, 2'd3), 16'h1234, 1'b0};
    tbl[8]  = '{mk(16'h2222, lin(100, 100), 8'hFF, 1, 0, 2'd0), 16'h2222, 1'b0};
    tbl[9]  = '{mk(16'h3333, lin(100, 100), 8'hFF, 0, 1, 2'd0), 16'h3333, 1'b0};
    tbl[10] = '{mk(16'h4444, lin(16'hFFFF, 0), 8'hFF, 1, 1, 2'd0), 16'hFFFF, 1'b1};
    nb = lin(16'hFFFF, 0); nb[2*W +: W] = 16'hFFFE;
    tbl[11] = '{mk(16'h5555, nb, 8'h07, 1, 1, 2'd0), 16'hFFFE, 1'b1};

    // Latency on an idle pipe
    b = tbl[0].b;
    e = '{data: tbl[0].exp_data, user: 1'b0, last: 1'b0, rep: tbl[0].exp_rep};
    send(b, e);
    got = 1'b0;
    for (int g = 0; g < 20 && !got; g++) begin
      @(negedge aclk);
      if (m_axis_tvalid) got = 1'b1;
    end
    check("latency_n_plus_3", 32'(cyc - acc_cyc), 3);
    drain();

    // Directed vector table, back to back
    for (int i = 0; i < 12; i++) begin
      b = tbl[i].b;
      b.user = (i == 0);
      b.last = (i == 11);
      e = '{data: tbl[i].exp_data, user: b.user, last: b.last, rep: tbl[i].exp_rep};
      send(b, e);
    end
    drain();

    // 20-beat line with a 5-cycle downstream stall mid-line
    fork
      for (int i = 0; i < 20; i++) begin
        b = rand_beat();
        b.user = (i == 0);
        b.last = (i == 19);
        send(b, model(b));
      end
      begin
        repeat (6) @(negedge aclk);
        rdy_mode = 2;
        repeat (4) @(negedge aclk);
        check("tready_low_pipe_full", {30'd0, s_axis_tready, m_axis_tvalid}, 32'd1);
        @(negedge aclk);
        rdy_mode = 0;
      end
    join
    drain();

    // Randomized traffic with random backpressure and idle gaps
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      b = rand_beat();
      b.user = ($urandom_range(19) == 0);
      b.last = ($urandom_range(7) == 0);
      send(b, model(b));
      if ($urandom_range(3) == 0) begin @(posedge aclk); #1; end
    end
    rdy_mode = 0;
    drain();

    // Frame statistics and reset mid-frame
    do_reset();
    p0 = pulses;
    send_frame(16'h0884, 16);
    drain();
    check("first_sof_no_pulse", 32'(pulses - p0), 0);
    send_frame(16'h0000, 6);
    check("frame2_sof_pulse", 32'(pulses - p0), STATS ? 32'd1 : 32'd0);
    check("frame2_sof_count", 32'(stat_bp_count), STATS ? 32'd3 : 32'd0);
    do_reset();
    check("count_cleared_by_reset", 32'(stat_bp_count), 0);
    p0 = pulses;
    send_frame(16'h0022, 16);
    drain();
    check("no_pulse_after_reset", 32'(pulses - p0), 0);
    send_frame(16'h0000, 1);
    drain();
    repeat (2) @(posedge aclk);
    #1;
    check("frame4_sof_pulse", 32'(pulses - p0), STATS ? 32'd1 : 32'd0);
    check("frame4_sof_count", 32'(stat_bp_count), STATS ? 32'd2 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
